// File: rtl/coarse_interval_counter.sv
// Coarse TDC interval counter: counts clk cycles from a start pulse to the next stop pulse.
// Latency: result_valid rises the cycle after the stop (or timeout) is sampled; all outputs registered.
// Backpressure: a result is held until result_valid && result_ready; pulses arriving while held are dropped.
// Optional feature macro: COARSE_TIMEOUT_EN (end a measurement at counter saturation, flagging timeout).
module coarse_interval_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_pulse,
  input  logic               stop_pulse,
  input  logic               result_ready,
  output logic               result_valid,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_timeout,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] res_count_q, res_count_d;
  logic               handshake;

  // The held result is consumed only while it is actually being presented.
  assign handshake = (state_q == S_HOLD) && result_ready;

`ifdef COARSE_TIMEOUT_EN
  logic res_timeout_q, res_timeout_d;
  logic at_max;

  // Saturation only matters in RUN; a stop in the same cycle takes priority.
  assign at_max = (count_q == CNT_MAX);
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      res_count_q <= '0;
`ifdef COARSE_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      res_count_q <= res_count_d;
`ifdef COARSE_TIMEOUT_EN
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  // Next-state logic: start arms, stop (or saturation) captures, handshake releases
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // Start wins over a coincident stop, so intervals are never zero-length.
        if (start_pulse) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_pulse) begin
          state_d = S_HOLD;
`ifdef COARSE_TIMEOUT_EN
        end else if (at_max) begin
          state_d = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        // A start in the handshake cycle begins the next measurement immediately.
        if (handshake) state_d = start_pulse ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter and result capture; count is 1 in the cycle after start so stop gives t1 - t0
  always_comb begin
    count_d     = '0;
    res_count_d = res_count_q;
`ifdef COARSE_TIMEOUT_EN
    res_timeout_d = res_timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_pulse) count_d = CNT_ONE;
      end
      S_RUN: begin
        if (stop_pulse) begin
          res_count_d = count_q;
`ifdef COARSE_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (at_max) begin
          res_count_d   = CNT_MAX;
          res_timeout_d = 1'b1;
`endif
        end else begin
          // Without saturation handling this wraps modulo 2^COUNT_W.
          count_d = count_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (handshake && start_pulse) count_d = CNT_ONE;
      end
      default: count_d = '0;
    endcase
  end

  // Outputs decoded purely from registers; result_ready has no path to any output
  always_comb begin
    result_valid = (state_q == S_HOLD);
    busy         = (state_q != S_IDLE);
    result_count = res_count_q;
`ifdef COARSE_TIMEOUT_EN
    result_timeout = res_timeout_q;
`else
    result_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_coarse_interval_counter.sv
// Directed bench for coarse_interval_counter: a 16-bit instance for the main
// behaviour and a 4-bit instance for the saturation / wrap boundary.
module tb_coarse_interval_counter;

  logic        clk;
  logic        reset;
  logic        start_pulse;
  logic        stop_pulse;
  logic        result_ready;

  logic        v16, t16, b16;
  logic [15:0] c16;
  logic        v4, t4, b4;
  logic [3:0]  c4;

  int n_checks;
  int n_fail;

  coarse_interval_counter #(.COUNT_W(16)) dut16 (
    .clk            (clk),
    .reset          (reset),
    .start_pulse    (start_pulse),
    .stop_pulse     (stop_pulse),
    .result_ready   (result_ready),
    .result_valid   (v16),
    .result_count   (c16),
    .result_timeout (t16),
    .busy           (b16)
  );

  coarse_interval_counter #(.COUNT_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .start_pulse    (start_pulse),
    .stop_pulse     (stop_pulse),
    .result_ready   (result_ready),
    .result_valid   (v4),
    .result_count   (c4),
    .result_timeout (t4),
    .busy           (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a one-cycle start pulse (sampled on the next edge).
  task automatic pulse_start();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_pulse = 1'b1;
    tick();
    stop_pulse = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ticks(3);
    reset = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    start_pulse  = 1'b0;
    stop_pulse   = 1'b0;
    result_ready = 1'b0;

    // Reset for three cycles, then release.
    do_reset();
    check("rst_valid",   32'(v16), 32'd0);
    check("rst_count",   32'(c16), 32'd0);
    check("rst_timeout", 32'(t16), 32'd0);
    check("rst_busy",    32'(b16), 32'd0);
    tick();
    check("rst_busy_idle", 32'(b16), 32'd0);

    // Start at edge t0, stop at edge t0+15 -> interval 15.
    pulse_start();
    check("run_busy",  32'(b16), 32'd1);
    check("run_valid", 32'(v16), 32'd0);
    ticks(14);
    check("run_novalid_pre_stop", 32'(v16), 32'd0);
    pulse_stop();
    check("m15_valid",   32'(v16), 32'd1);
    check("m15_count",   32'(c16), 32'd15);
    check("m15_timeout", 32'(t16), 32'd0);

    // Result held 20 cycles without ready while extra pulses are dropped.
    for (int i = 0; i < 20; i++) begin
      start_pulse = (i % 3 == 0);
      stop_pulse  = (i % 4 == 1);
      tick();
    end
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    check("hold_valid", 32'(v16), 32'd1);
    check("hold_count", 32'(c16), 32'd15);
    check("hold_busy",  32'(b16), 32'd1);
    accept();
    check("hs_valid_fall", 32'(v16), 32'd0);
    check("hs_busy_fall",  32'(b16), 32'd0);
    tick();
    check("hs_extra_pulses_dropped", 32'(b16), 32'd0);

    // Back-to-back: ready and start in the same cycle goes straight to RUN.
    pulse_start();
    ticks(4);
    pulse_stop();
    check("m5_count", 32'(c16), 32'd5);
    result_ready = 1'b1;
    start_pulse  = 1'b1;
    tick();
    result_ready = 1'b0;
    start_pulse  = 1'b0;
    check("b2b_busy",  32'(b16), 32'd1);
    check("b2b_valid", 32'(v16), 32'd0);
    ticks(6);
    pulse_stop();
    check("b2b_valid_res", 32'(v16), 32'd1);
    check("b2b_count",     32'(c16), 32'd7);
    accept();
    check("b2b_idle", 32'(b16), 32'd0);

    // Start and stop together in IDLE: start taken, no result.
    start_pulse = 1'b1;
    stop_pulse  = 1'b1;
    tick();
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    check("ss_busy",  32'(b16), 32'd1);
    check("ss_valid", 32'(v16), 32'd0);
    ticks(3);
    check("ss_still_running", 32'(v16), 32'd0);
    pulse_stop();
    check("ss_count", 32'(c16), 32'd4);
    accept();

    // Stop alone in IDLE does nothing.
    pulse_stop();
    check("stop_idle_busy",  32'(b16), 32'd0);
    check("stop_idle_valid", 32'(v16), 32'd0);

    // Reset mid-RUN discards the measurement.
    pulse_start();
    ticks(3);
    reset = 1'b0;
    tick();
    check("rst_run_valid", 32'(v16), 32'd0);
    check("rst_run_busy",  32'(b16), 32'd0);
    reset = 1'b1;

    // Reset mid-HOLD discards the pending result.
    pulse_start();
    ticks(2);
    pulse_stop();
    check("pre_rst_hold_valid", 32'(v16), 32'd1);
    reset = 1'b0;
    tick();
    check("rst_hold_valid", 32'(v16), 32'd0);
    check("rst_hold_busy",  32'(b16), 32'd0);
    check("rst_hold_count", 32'(c16), 32'd0);
    reset = 1'b1;
    pulse_start();
    ticks(7);
    pulse_stop();
    check("post_rst_count", 32'(c16), 32'd8);
    check("post_rst_valid", 32'(v16), 32'd1);
    accept();

    // 4-bit instance: stop exactly as the counter reaches max -> stop wins.
    do_reset();
    check("w4_rst_busy", 32'(b4), 32'd0);
    pulse_start();
    ticks(14);
    check("w4_max_novalid", 32'(v4), 32'd0);
    pulse_stop();
    check("w4_stopmax_count",   32'(c4), 32'd15);
    check("w4_stopmax_timeout", 32'(t4), 32'd0);
    accept();

    // 4-bit instance: start and no stop.
    pulse_start();
    ticks(14);
    check("w4_pre_sat_valid", 32'(v4), 32'd0);
    tick();
`ifdef COARSE_TIMEOUT_EN
    check("w4_to_valid",   32'(v4), 32'd1);
    check("w4_to_count",   32'(c4), 32'd15);
    check("w4_to_timeout", 32'(t4), 32'd1);
    pulse_stop();
    check("w4_to_late_stop_count", 32'(c4), 32'd15);
    check("w4_to_late_stop_flag",  32'(t4), 32'd1);
    accept();
    check("w4_to_idle", 32'(b4), 32'd0);
`else
    check("w4_wrap_valid", 32'(v4), 32'd0);
    ticks(4);
    check("w4_wrap_running", 32'(b4), 32'd1);
    pulse_stop();
    check("w4_wrap_valid_res", 32'(v4), 32'd1);
    check("w4_wrap_count",     32'(c4), 32'd4);
    check("w4_wrap_timeout",   32'(t4), 32'd0);
    accept();
    check("w4_wrap_idle", 32'(b4), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coarse_interval_counter.md
# coarse_interval_counter

Downstream consumer of the one-cycle rising-edge pulses produced by the TDC edge-detector stage. It measures the coarse interval, in `clk` cycles, between a start pulse and the following stop pulse. It holds the result behind a valid/ready handshake until the readout logic takes it. Its output is the coarse part of each TDC measurement, later merged with the fine (delay-line) code.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the interval counter and of `result_count`; legal range 4..32.

Ports:
- `clk`  input  1: single clock; all logic is on its rising edge.
- `reset`  input  1: synchronous, active-low reset (asserted when 0).
- `start_pulse`  input  1: one-cycle start event from the start-channel edge detector.
- `stop_pulse`  input  1: one-cycle stop event from the stop-channel edge detector.
- `result_ready`  input  1: consumer accepts the result.
- `result_valid`  output  1: `result_count` and `result_timeout` are valid.
- `result_count`  output  `COUNT_W`: measured interval in clk cycles.
- `result_timeout`  output  1: the measurement ended at counter saturation rather than on a stop pulse.
- `busy`  output  1: a measurement is running or a result is pending (state ≠ IDLE).

## Operation
- State machine: IDLE, RUN, HOLD.
- IDLE:
  - `count` = 0.
  - `start_pulse` → RUN, `count` ← 1.
  - `stop_pulse` alone is ignored.
  - If `start_pulse` and `stop_pulse` arrive in the same cycle, start is taken and stop is ignored; there are no zero-length intervals.
- RUN:
  - `count` increments by 1 every cycle.
  - `stop_pulse` → HOLD; `result_count` ← current `count`, `result_timeout` ← 0.
  - `start_pulse` in RUN is ignored; there is no re-arm.
- Interval definition: start pulse at cycle t0 and stop at cycle t1 give `result_count` = t1 − t0.
- Counter at max (2^`COUNT_W` − 1) with no stop: behaviour is set by the macro (see Configuration).
- Stop in the same cycle as the counter reaching max: stop wins, `result_count` = max, `result_timeout` = 0.
- HOLD:
  - `result_valid` = 1; `result_count` and `result_timeout` stay stable until the handshake.
  - `result_valid` && `result_ready` → IDLE.
  - If `start_pulse` arrives in the handshake cycle → RUN directly with `count` ← 1 (back-to-back measurement).
  - `start_pulse` or `stop_pulse` in HOLD without the handshake is dropped.
- Width rule: `count` is unsigned `COUNT_W` bits; no arithmetic beyond the +1 increment.

## Timing
- Reset values: `result_valid` 0, `result_count` 0, `result_timeout` 0, `busy` 0; state IDLE; `count` 0.
- Reset is sampled on the clk edge and overrides every other input in that cycle. Reset during RUN or HOLD discards the measurement and any pending result.
- Latency: `result_valid` rises in the cycle after the stop pulse is sampled; all outputs are registered.
- `busy` rises in the cycle after the start pulse is accepted. It falls in the cycle after the handshake, unless a start is accepted in the handshake cycle, in which case it stays high.
- Handshake: the transfer happens on a cycle with `result_valid` && `result_ready`. `result_ready` while `result_valid` = 0 has no effect. There is no combinational path from `result_ready` to any output.
- Throughput: at most one result per (interval + 2) cycles without back-to-back start; interval + 1 with it.

## Configuration
- `COARSE_TIMEOUT_EN` defined:
  - In RUN with `count` = max and no stop → HOLD with `result_count` = max and `result_timeout` = 1.
  - A later stop pulse for that measurement is ignored.
- `COARSE_TIMEOUT_EN` undefined:
  - `count` wraps modulo 2^`COUNT_W` and RUN continues until a stop pulse.
  - `result_timeout` is constant 0; the timeout logic is not synthesized.

## Test plan
- Reset low for 3 cycles, then release → all outputs 0, `busy` 0. Then apply start at cycle 10 and stop at cycle 25 → `result_valid` at cycle 26, `result_count` = 15, `result_timeout` = 0.
- Hold `result_ready` = 0 for 20 cycles after a result and send extra start/stop pulses → result stays stable and the extra pulses are dropped. Then raise `result_ready` → `result_valid` falls the next cycle and `busy` = 0.
- Assert `result_ready` and `start_pulse` in the same cycle → state goes to RUN. Stop 7 cycles later → `result_count` = 7.
- With `COUNT_W` = 4, start and no stop:
  - With `COARSE_TIMEOUT_EN`: `result_count` = 15 and `result_timeout` = 1, 16 cycles after start.
  - Without it: stop 20 cycles after start → `result_count` = 4.
- Start and stop in the same IDLE cycle → state is RUN and there is no result. Stop alone in IDLE → nothing happens.
- Drive reset low mid-RUN and mid-HOLD → next cycle `result_valid` = 0, `busy` = 0, and a new measurement after release is correct.
